pll_rst_seq: RTL and testbench
==============================

Name: pll_rst_seq

Overview:
- Companion controller for the on-chip PLL wrapper. It drives the PLL reset and consumes the PLL lock output.
- Issues a timed reset pulse to the PLL, synchronizes and qualifies the lock signal, and applies a lock timeout with bounded retries.
- Releases a downstream reset only after lock has been stable for a set time. Loss of lock re-triggers the PLL reset.
- Runs on the free-running reference clock that also feeds the PLL input, not on any PLL output clock.

Parameters:
- RST_CYCLES, 16: length of the pll_rst pulse in clk cycles (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024: consecutive cycles of synchronized lock required before release.
- MAX_RETRY, 4: number of timeouts allowed before entering FAIL (≥1).
- SYNC_STAGES, 2: flip-flop depth of the pll_lock synchronizer (≥2).

Ports:
- clk  in  1  free-running reference clock.
- rst  in  1  synchronous, active-high reset.
- pll_lock  in  1  PLL lock, asynchronous to clk.
- restart  in  1  single-cycle software request to re-run the sequence from RESET.
- pll_rst  out  1  PLL reset, active high.
- user_rst  out  1  downstream reset, active high; low only in RUN.
- pll_ready  out  1  high only in RUN.
- pll_fail  out  1  high only in FAIL.
- retry_cnt  out  $clog2(MAX_RETRY+1)  number of timeouts in the current attempt.

Behaviour:
- Reset values (rst=1): state=RESET, counter=0, retry_cnt=0, pll_rst=1, user_rst=1, pll_ready=0, pll_fail=0, synchronizer flops=0.
- All outputs are registered. They are decoded from the next state, so each output changes on the same edge as the state register.
- lock_s is pll_lock after SYNC_STAGES flops. It lags pll_lock by SYNC_STAGES cycles. Only lock_s is used internally.
- Priority: rst, then restart, then the state logic.
- restart=1 in any state: go to RESET, clear counter and retry_cnt.
- RESET: pll_rst=1, user_rst=1. The counter counts up.
  - When the counter reaches RST_CYCLES-1: go to WAIT_LOCK and clear the counter.
  - pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK: pll_rst=0, user_rst=1. The counter counts up.
  - lock_s=1: go to STABLE and clear the counter. Lock has priority over timeout in the same cycle.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0: retry_cnt is incremented.
  - If the new retry_cnt equals MAX_RETRY: go to FAIL. Otherwise go to RESET. The counter is cleared in both cases.
- STABLE: pll_rst=0, user_rst=1.
  - lock_s=0: go to WAIT_LOCK and clear the counter. The timeout window restarts and retry_cnt is unchanged.
  - Counter reaches STABLE_CYCLES-1 with lock_s=1: go to RUN and clear retry_cnt.
- RUN: user_rst=0, pll_ready=1.
  - lock_s=0: go to RESET. user_rst=1 and pll_ready=0 on that same edge. retry_cnt is not incremented.
- FAIL: pll_rst=1, user_rst=1, pll_fail=1. The block stays here until rst or restart.
- Counter width is $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. The counter never wraps; it is cleared on every state change.
- retry_cnt saturates at MAX_RETRY.
- Glitches in pll_lock shorter than one clk period may be missed; this is acceptable.

Optional Feature:
- Macro PLL_RST_SEQ_LOSS_CNT_EN.
- When defined:
  - Adds output loss_cnt [15:0], a saturating count of RUN→RESET transitions caused by lock loss.
  - Cleared by rst only; restart does not clear it. It holds at 16'hFFFF.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2, SYNC_STAGES=2):
- Nominal lock: release rst; pll_lock rises 10 cycles after pll_rst falls and stays high.
  - Required: pll_rst high exactly 4 cycles; user_rst falls and pll_ready rises 20 cycles after pll_rst falls; retry_cnt=0.
- Lock glitch in STABLE: pll_lock drops for 3 cycles at STABLE count 5.
  - Required: return to WAIT_LOCK, no pll_rst pulse; after lock returns, a full 8 further stable cycles are needed before release.
- Single timeout: hold pll_lock=0.
  - Required: after 32 WAIT_LOCK cycles, retry_cnt=1 and a second 4-cycle pll_rst pulse.
  - Raise lock on the second attempt: RUN is reached and retry_cnt returns to 0.
- Failure: hold pll_lock=0 throughout.
  - Required: after the second timeout, pll_fail=1, pll_rst=1 held, retry_cnt=2.
  - Pulse restart: pll_fail=0, retry_cnt=0, new sequence begins.
- Lock loss in RUN: drop pll_lock.
  - Required: 2 cycles later user_rst=1, pll_ready=0 and pll_rst=1 for 4 cycles.
  - With the macro defined, loss_cnt increments 0→1.
- Reset mid-sequence: assert rst during STABLE.
  - Required: next edge shows every output at its reset value, and RESET timing restarts from 0.

Source files
------------

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: reset/lock sequencer for the on-chip PLL wrapper.
// Pulses the PLL reset, waits for a synchronized and qualified lock (with a
// timeout and bounded retries), then releases the downstream reset. Losing
// lock while running restarts the whole sequence. Runs on the PLL reference
// clock, never on a PLL output clock.
// Optional build macro: PLL_RST_SEQ_LOSS_CNT_EN adds a saturating loss_cnt
// output counting RUN->RESET transitions caused by lock loss.
module pll_rst_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pll_lock,
    input  logic                             restart,
    output logic                             pll_rst,
    output logic                             user_rst,
    output logic                             pll_ready,
    output logic                             pll_fail,
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    output logic [15:0]                      loss_cnt,
`endif
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

    // Counter must hold the largest terminal count of any timed state.
    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW      = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [RW-1:0]   retry_reg, retry_next;
    logic [RW-1:0]   retry_inc;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic            lock_s;
    logic            pll_rst_next, user_rst_next, pll_ready_next, pll_fail_next;

    // Lock synchronizer: pll_lock is asynchronous, only the last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_reg[SYNC_STAGES-1];

    // Timeout count saturates so retry_cnt can never exceed MAX_RETRY.
    assign retry_inc = (retry_reg == RETRY_MAX) ? retry_reg : retry_reg + RW'(1);

    // Next-state, counter and retry logic; restart overrides every state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        if (restart) begin
            state_next = ST_RESET;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            unique case (state_reg)
                ST_RESET: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a timeout landing on the same cycle.
                    if (lock_s) begin
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == LOCK_LAST) begin
                        retry_next = retry_inc;
                        state_next = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                ST_STABLE: begin
                    // A dropout restarts the lock window without re-resetting the PLL.
                    if (!lock_s) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                        retry_next = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_next = ST_RESET;
                        cnt_next   = '0;
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_RESET;
                    cnt_next   = '0;
                    retry_next = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move with the state register.
    always_comb begin
        pll_rst_next   = 1'b0;
        user_rst_next  = 1'b1;
        pll_ready_next = 1'b0;
        pll_fail_next  = 1'b0;
        unique case (state_next)
            ST_RESET:     pll_rst_next = 1'b1;
            ST_WAIT_LOCK: pll_rst_next = 1'b0;
            ST_STABLE:    pll_rst_next = 1'b0;
            ST_RUN: begin
                user_rst_next  = 1'b0;
                pll_ready_next = 1'b1;
            end
            ST_FAIL: begin
                pll_rst_next  = 1'b1;
                pll_fail_next = 1'b1;
            end
            default:      pll_rst_next = 1'b1;
        endcase
    end

    // State, counter, retry and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RESET;
            cnt_reg   <= '0;
            retry_reg <= '0;
            pll_rst   <= 1'b1;
            user_rst  <= 1'b1;
            pll_ready <= 1'b0;
            pll_fail  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            retry_reg <= retry_next;
            pll_rst   <= pll_rst_next;
            user_rst  <= user_rst_next;
            pll_ready <= pll_ready_next;
            pll_fail  <= pll_fail_next;
        end
    end

    assign retry_cnt = retry_reg;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic [15:0] loss_reg;
    logic        loss_hit;

    // Only a genuine lock loss in RUN counts; a restart in the same cycle does not.
    assign loss_hit = !restart && (state_reg == ST_RUN) && !lock_s;

    // Saturating loss counter, survives restart and clears only on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_reg <= '0;
        end else if (loss_hit && (loss_reg != 16'hFFFF)) begin
            loss_reg <= loss_reg + 16'd1;
        end
    end

    assign loss_cnt = loss_reg;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: scoreboard bench for pll_rst_seq with a behavioural model.
// Stimulus pushes the model's expected outputs per clock; a monitor pops and
// compares after every rising edge. Directed phases follow the test plan,
// then a randomized lock/restart/reset phase runs.
module tb_pll_rst_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;
    localparam int SYNC_STAGES   = 2;
    localparam int RW            = $clog2(MAX_RETRY + 1);

    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic          pll_lock;
    logic          pll_rst;
    logic          user_rst;
    logic          pll_ready;
    logic          pll_fail;
    logic [RW-1:0] retry_cnt;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic [15:0]   loss_cnt;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic          prst;
        logic          urst;
        logic          ready;
        logic          fail;
        logic [RW-1:0] retry;
        logic [15:0]   loss;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: current phase, cycles spent in it, retries, losses,
    // and the lock samples still travelling through the synchronizer.
    int m_phase   = P_RESET;
    int m_elapsed = 0;
    int m_retries = 0;
    int m_losses  = 0;
    bit lock_pipe[$];

    pll_rst_seq #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .restart  (restart),
        .pll_rst  (pll_rst),
        .user_rst (user_rst),
        .pll_ready(pll_ready),
        .pll_fail (pll_fail),
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        .loss_cnt (loss_cnt),
`endif
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the currently driven inputs.
    function automatic void model_edge();
        bit   seen;
        exp_t e;
        seen = lock_pipe.pop_front();
        lock_pipe.push_back(pll_lock);
        if (rst) begin
            lock_pipe = {};
            for (int i = 0; i < SYNC_STAGES; i++) lock_pipe.push_back(1'b0);
            m_phase = P_RESET; m_elapsed = 0; m_retries = 0; m_losses = 0;
        end else if (restart) begin
            m_phase = P_RESET; m_elapsed = 0; m_retries = 0;
        end else begin
            case (m_phase)
                P_RESET: begin
                    m_elapsed++;
                    if (m_elapsed == RST_CYCLES) begin m_phase = P_WAIT; m_elapsed = 0; end
                end
                P_WAIT: begin
                    m_elapsed++;
                    if (seen) begin
                        m_phase = P_STABLE; m_elapsed = 0;
                    end else if (m_elapsed == LOCK_TIMEOUT) begin
                        if (m_retries < MAX_RETRY) m_retries++;
                        m_phase   = (m_retries == MAX_RETRY) ? P_FAIL : P_RESET;
                        m_elapsed = 0;
                    end
                end
                P_STABLE: begin
                    m_elapsed++;
                    if (!seen) begin
                        m_phase = P_WAIT; m_elapsed = 0;
                    end else if (m_elapsed == STABLE_CYCLES) begin
                        m_phase = P_RUN; m_elapsed = 0; m_retries = 0;
                    end
                end
                P_RUN: begin
                    if (!seen) begin
                        m_phase = P_RESET; m_elapsed = 0;
                        if (m_losses < 65535) m_losses++;
                    end
                end
                default: ;
            endcase
        end
        e.prst  = (m_phase == P_RESET) || (m_phase == P_FAIL);
        e.urst  = (m_phase != P_RUN);
        e.ready = (m_phase == P_RUN);
        e.fail  = (m_phase == P_FAIL);
        e.retry = RW'(m_retries);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        e.loss  = 16'(m_losses);
`else
        e.loss  = 16'd0;
`endif
        exp_q.push_back(e);
    endfunction

    // One clock: model the coming edge, then land on the following falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    // Bounded wait until the model reaches a phase/elapsed point.
    task automatic wait_model(input int phase, input int elapsed, input string name);
        int n;
        n = 0;
        while (!(m_phase == phase && m_elapsed == elapsed) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk({name, "_timeout"}, 0, 1);
    endtask

    // Bounded wait until the DUT reports ready.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!pll_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk({name, "_timeout"}, 0, 1);
    endtask

    // Counts how many consecutive sampled cycles pll_rst stays high, starting now.
    task automatic measure_rst_width(input string name);
        int n;
        n = 1;
        while (n < 50) begin
            step();
            if (!pll_rst) break;
            n++;
        end
        chk(name, n, RST_CYCLES);
    endtask

    // Monitor: compare every edge's outputs with the queued expectation.
    initial begin
        exp_t e;
        exp_t a;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.prst  = pll_rst;
                a.urst  = user_rst;
                a.ready = pll_ready;
                a.fail  = pll_fail;
                a.retry = retry_cnt;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
                a.loss  = loss_cnt;
`else
                a.loss  = 16'd0;
`endif
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL cycle_%0d: got rst=%b urst=%b rdy=%b fail=%b retry=%0d loss=%0d, required rst=%b urst=%b rdy=%b fail=%b retry=%0d loss=%0d",
                             cyc, a.prst, a.urst, a.ready, a.fail, a.retry, a.loss,
                             e.prst, e.urst, e.ready, e.fail, e.retry, e.loss);
                end
            end
        end
    end

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "time limit");
    end

    // Stimulus.
    initial begin
        int n;
        int seen_rst;
        for (int i = 0; i < SYNC_STAGES; i++) lock_pipe.push_back(1'b0);
        rst = 1'b1; restart = 1'b0; pll_lock = 1'b0;
        repeat (3) step();
        chk("reset_pll_rst", pll_rst, 1);
        chk("reset_user_rst", user_rst, 1);
        chk("reset_ready", pll_ready, 0);
        chk("reset_fail", pll_fail, 0);
        chk("reset_retry", retry_cnt, 0);

        // Nominal lock: lock seen at the 10th edge after pll_rst falls.
        rst = 1'b0;
        measure_rst_width("nominal_pll_rst_width");
        repeat (9) step();
        pll_lock = 1'b1;
        n = 9;
        while (n < 100) begin
            step();
            n++;
            if (pll_ready) break;
        end
        chk("nominal_fall_to_ready", n, 20);
        chk("nominal_user_rst", user_rst, 0);
        chk("nominal_retry", retry_cnt, 0);

        // Lock glitch during STABLE: back to WAIT_LOCK, no PLL reset.
        restart = 1'b1; step(); restart = 1'b0;
        wait_model(P_STABLE, 5, "glitch_reach");
        pll_lock = 1'b0;
        repeat (3) step();
        pll_lock = 1'b1;
        n = 0; seen_rst = 0;
        while (n < 60) begin
            step();
            n++;
            if (pll_rst) seen_rst = 1;
            if (pll_ready) break;
        end
        chk("glitch_no_pll_rst", seen_rst, 0);
        chk("glitch_return_to_ready", n, SYNC_STAGES + 1 + STABLE_CYCLES);

        // Single timeout, then lock on the second attempt.
        pll_lock = 1'b0;
        restart = 1'b1; step(); restart = 1'b0;
        n = 0;
        while (retry_cnt != 1 && n < 200) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, RST_CYCLES + LOCK_TIMEOUT);
        chk("timeout_retry", retry_cnt, 1);
        measure_rst_width("timeout_pll_rst_width");
        pll_lock = 1'b1;
        wait_ready("retry_ready");
        chk("retry_cleared_in_run", retry_cnt, 0);

        // Failure after MAX_RETRY timeouts, then recovery by restart.
        pll_lock = 1'b0;
        restart = 1'b1; step(); restart = 1'b0;
        n = 0;
        while (!pll_fail && n < 300) begin
            step();
            n++;
        end
        chk("fail_reached", pll_fail, 1);
        chk("fail_retry", retry_cnt, MAX_RETRY);
        chk("fail_pll_rst", pll_rst, 1);
        repeat (10) step();
        chk("fail_holds", pll_fail, 1);
        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_fail_clear", pll_fail, 0);
        chk("restart_retry_clear", retry_cnt, 0);
        chk("restart_pll_rst", pll_rst, 1);

        // Lock loss while running.
        pll_lock = 1'b1;
        wait_ready("loss_ready");
        pll_lock = 1'b0;
        repeat (2) step();
        chk("loss_ready_still_high", pll_ready, 1);
        step();
        chk("loss_user_rst", user_rst, 1);
        chk("loss_ready_low", pll_ready, 0);
        chk("loss_retry", retry_cnt, 0);
        chk("loss_pll_rst", pll_rst, 1);
        measure_rst_width("loss_pll_rst_width");
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        chk("loss_cnt_one", loss_cnt, 1);
`endif

        // Synchronous reset in the middle of STABLE.
        pll_lock = 1'b1;
        wait_model(P_STABLE, 3, "midrst_reach");
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_pll_rst", pll_rst, 1);
        chk("midrst_user_rst", user_rst, 1);
        chk("midrst_ready", pll_ready, 0);
        chk("midrst_fail", pll_fail, 0);
        chk("midrst_retry", retry_cnt, 0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        chk("midrst_loss_cnt", loss_cnt, 0);
`endif
        measure_rst_width("midrst_pll_rst_width");

        // Randomized segments of lock behaviour, restarts and resets.
        for (int s = 0; s < 120; s++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 4);
            case (mode)
                0: begin
                    len = $urandom_range(10, 80);
                    pll_lock = 1'b1;
                    repeat (len) step();
                end
                1: begin
                    len = $urandom_range(10, 120);
                    pll_lock = 1'b0;
                    repeat (len) step();
                end
                2: begin
                    len = $urandom_range(5, 20);
                    for (int i = 0; i < len; i++) begin
                        pll_lock = 1'($urandom_range(0, 1));
                        step();
                    end
                end
                3: begin
                    restart = 1'b1; step(); restart = 1'b0;
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1; step(); rst = 1'b0;
                    end else begin
                        pll_lock = 1'b1;
                        repeat (30) step();
                    end
                end
            endcase
        end

        repeat (2) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
